reg_chain_seq: RTL and testbench
================================

// Module: reg_chain_seq
// PURPOSE
//  Sequencer for the SoC register-chain datapath: loads a seed value into chain stage r0, then issues
//  DEPTH-1 spaced shift pulses so the seed propagates r0->r(DEPTH-1). Selects one stage for readback
//  from the board switches and drives the 16-bit LED bus with status plus the selected value.
//  Sits between soc_mini_top's board I/O (switch/init_num/led) and the register-chain datapath.
// PARAMETERS
//  WIDTH    8  data width of one chain stage (1..8; zero-extended onto led[7:0])
//  DEPTH    8  number of chain stages (2..64)
//  TICK_DIV 4  clock cycles between consecutive shift pulses (>=1; 1 = shift every cycle)
// PORTS
//  clk            in   1           system clock, all logic rising-edge
//  reset          in   1           synchronous, active-high reset
//  start          in   1           run request, sampled only in IDLE
//  step           in   1           manual shift advance (used only with REG_CHAIN_STEP_EN)
//  init_num       in   WIDTH       seed value, captured on accepted start
//  switch         in   8           readback stage select
//  chain_load     out  1           1-cycle pulse: chain writes chain_din into r0
//  chain_din      out  WIDTH       seed presented to r0
//  chain_shift    out  1           1-cycle pulse: every stage r(i+1) <= r(i)
//  chain_rd_sel   out  clog2(DEPTH) readback stage index
//  chain_rd_data  in   WIDTH       value of stage chain_rd_sel (combinational from chain)
//  busy           out  1           high from LOAD through DONE
//  done           out  1           1-cycle pulse at end of run
//  led            out  16          {busy, done_sticky, shift_cnt[5:0], rd_q[7:0]}
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE; chain_load, chain_shift, busy, done, done_sticky,
//    shift_cnt, tick counter, chain_din, rd_q = 0; led=16'h0000; chain_rd_sel follows switch next cycle.
//  - FSM IDLE->LOAD->WAIT->SHIFT->(WAIT|DONE)->IDLE.
//    IDLE: start=1 at cycle N -> LOAD at N+1; chain_din <= init_num, chain_load=1, busy=1,
//      shift_cnt=0, done_sticky cleared.
//    LOAD->WAIT (or directly SHIFT if TICK_DIV==1). WAIT lasts TICK_DIV-1 cycles.
//    SHIFT: chain_shift=1 for exactly 1 cycle, shift_cnt++. If shift_cnt reaches DEPTH-1 -> DONE, else WAIT.
//    DONE: done=1 for 1 cycle, done_sticky<=1, busy stays 1 this cycle; next cycle IDLE, busy=0.
//  - Timing: load at N+1, shift k (1..DEPTH-1) at N+1+k*TICK_DIV, done at N+2+(DEPTH-1)*TICK_DIV.
//  - chain_load and chain_shift never both high; at most one pulse per cycle.
//  - start while busy: ignored, no restart, no queuing. start held high: new run after DONE->IDLE.
//  - init_num changes mid-run: no effect (captured at accept).
//  - Readback: chain_rd_sel <= (switch < DEPTH) ? switch : DEPTH-1 (clamp); rd_q <= chain_rd_data,
//    so led[7:0] reflects a switch change 2 cycles later. led[13:8] = shift_cnt zero-extended/truncated to 6 bits.
//  - done_sticky holds until next accepted start or reset.
//  - reset at any cycle, including mid-run: next cycle IDLE, no further load/shift pulses, done not raised.
// CONFIGURATION
//  REG_CHAIN_STEP_EN defined: WAIT does not use the tick counter; it stays in WAIT until step=1, and
//    the first step=1 cycle moves to SHIFT (one shift per step cycle; step held high = shift every 2 cycles).
//    step in LOAD/SHIFT/DONE/IDLE ignored.
//  REG_CHAIN_STEP_EN undefined: step port present but ignored; timing purely TICK_DIV-driven.
// STRUCTURE
//  - Shared include reg_chain_defs.vh: FSM state encodings (ST_IDLE/LOAD/WAIT/SHIFT/DONE, 3 bits),
//    led field positions, default WIDTH/DEPTH constants shared with the chain datapath.
//  - One sub-module: reg_chain_tick: TICK_DIV prescaler, inputs clk/reset/clear/en, output tick
//    pulse; cleared on LOAD and SHIFT. Rest (FSM, counters, readback) stays flat in reg_chain_seq.
// TESTING  (DEPTH=8, TICK_DIV=4, WIDTH=8 unless noted)
//  1 reset=1 for 10 cycles with start=1, switch=4 -> chain_load/chain_shift/busy/done stay 0, led=16'h0000.
//  2 start pulse at N, init_num=37 -> chain_load at N+1 with chain_din=8'h25; chain_shift at N+5,9,..,29
//    (7 pulses); done at N+30; busy N+1..N+30; led[15:8]=8'h47 after run; with a model chain
//    and switch=4, led[7:0]=8'h25 after run.
//  3 second start at N+12 (mid-run) -> ignored: still exactly 7 shifts, a single done at N+30.
//  4 reset at N+10 (after 2 shifts) -> N+11: busy=0, no further shifts, done never pulses, led[15:8]=0.
//  5 idle, switch 4->9 -> chain_rd_sel=4 then 7 (clamped); led[7:0] tracks chain_rd_data 2 cycles after switch.
//  6 REG_CHAIN_STEP_EN, TICK_DIV=4: start, then 7 step pulses spaced 10 cycles -> each chain_shift 1
//    cycle after its step; no shift without step; done 1 cycle after 7th shift.

Source files
------------

// File: rtl/reg_chain_seq_pkg.sv
// -----------------------------------------------------------------------------
// reg_chain_seq_pkg
// Shared definitions for the register-chain sequencer and its datapath:
//   - FSM state encoding (3 bits)
//   - LED bus field positions
//   - default chain geometry and shift spacing
// -----------------------------------------------------------------------------
package reg_chain_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_TICK_DIV = 4;

    // led = {busy, done_sticky, shift_cnt[5:0], rd_q[7:0]}
    localparam int LED_BUSY_BIT   = 15;
    localparam int LED_STICKY_BIT = 14;
    localparam int LED_CNT_LSB    = 8;
    localparam int LED_CNT_W      = 6;
    localparam int LED_RD_LSB     = 0;
    localparam int LED_RD_W       = 8;

endpackage

// File: rtl/reg_chain_tick.sv
// -----------------------------------------------------------------------------
// reg_chain_tick
// Prescaler that spaces the chain shift pulses. Counts while enabled and
// raises tick during the last cycle of a TICK_DIV-1 cycle wait window.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   clear in  restart the wait window (asserted in LOAD and SHIFT)
//   en    in  count enable (asserted in WAIT)
//   tick  out high in the final wait cycle
// -----------------------------------------------------------------------------
module reg_chain_tick
    import reg_chain_seq_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // The window is TICK_DIV-1 cycles long, counted 0..TICK_DIV-2.
    localparam int LAST = (TICK_DIV > 1) ? (TICK_DIV - 2) : 0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CW{1'b0}};
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CW'(LAST));

endmodule

// File: rtl/reg_chain_seq.sv
// -----------------------------------------------------------------------------
// reg_chain_seq
// Sequencer for the register-chain datapath: loads a seed into stage r0,
// then issues DEPTH-1 spaced shift pulses so the seed reaches r(DEPTH-1).
// Also selects a stage for readback and drives the LED status bus.
// Build option:
//   REG_CHAIN_STEP_EN  shifts advance on the step input instead of the
//                      TICK_DIV prescaler (step ignored when undefined).
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   start          run request, only honoured in IDLE
//   step           manual shift advance (REG_CHAIN_STEP_EN builds)
//   init_num       seed, captured when start is accepted
//   switch         readback stage select (clamped to DEPTH-1)
//   chain_load     1-cycle pulse: chain writes chain_din into r0
//   chain_din      seed presented to r0
//   chain_shift    1-cycle pulse: every stage shifts up by one
//   chain_rd_sel   readback stage index
//   chain_rd_data  value of the selected stage
//   busy           high from LOAD through DONE
//   done           1-cycle pulse at the end of a run
//   led            {busy, done_sticky, shift_cnt[5:0], rd_q[7:0]}
// All outputs come straight from flops; each pulse register is loaded from
// the next state so it lines up with the state it belongs to.
// -----------------------------------------------------------------------------
module reg_chain_seq
    import reg_chain_seq_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       step,
    input  logic [WIDTH-1:0]           init_num,
    input  logic [7:0]                 switch,
    output logic                       chain_load,
    output logic [WIDTH-1:0]           chain_din,
    output logic                       chain_shift,
    output logic [$clog2(DEPTH)-1:0]   chain_rd_sel,
    input  logic [WIDTH-1:0]           chain_rd_data,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                led
);

    localparam int SW = $clog2(DEPTH);

`ifdef REG_CHAIN_STEP_EN
    localparam bit NO_WAIT = 1'b0;
`else
    // With a one-cycle spacing there is no wait window at all.
    localparam bit NO_WAIT = (TICK_DIV == 1);
`endif

    state_e           state_q,  state_d;
    logic [SW-1:0]    shift_cnt_q, shift_cnt_d;
    logic [WIDTH-1:0] din_q,    din_d;
    logic             load_q,   load_d;
    logic             shift_q,  shift_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             sticky_q, sticky_d;
    logic [SW-1:0]    rd_sel_q, rd_sel_d;
    logic [WIDTH-1:0] rd_q,     rd_d;
    logic             tick_s;
    logic [15:0]      led_s;

    reg_chain_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear ((state_q == ST_LOAD) || (state_q == ST_SHIFT)),
        .en    (state_q == ST_WAIT),
        .tick  (tick_s)
    );

`ifdef REG_CHAIN_STEP_EN
    logic unused_tick_s;
    assign unused_tick_s = tick_s;
`else
    logic unused_step_s;
    assign unused_step_s = step;
`endif

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = NO_WAIT ? ST_SHIFT : ST_WAIT;
            end
            ST_WAIT: begin
`ifdef REG_CHAIN_STEP_EN
                if (step) begin
`else
                if (tick_s) begin
`endif
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SHIFT: begin
                // shift_cnt_q already includes the shift issued this cycle.
                if (shift_cnt_q == SW'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                end else if (NO_WAIT) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output, counter and readback next values derived from the next state.
    always_comb begin
        load_d  = (state_d == ST_LOAD);
        shift_d = (state_d == ST_SHIFT);
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
        rd_d    = chain_rd_data;

        if (state_d == ST_LOAD) begin
            din_d       = init_num;
            shift_cnt_d = {SW{1'b0}};
            sticky_d    = 1'b0;
        end else if (state_d == ST_SHIFT) begin
            din_d       = din_q;
            shift_cnt_d = shift_cnt_q + SW'(1);
            sticky_d    = sticky_q;
        end else if (state_d == ST_DONE) begin
            din_d       = din_q;
            shift_cnt_d = shift_cnt_q;
            sticky_d    = 1'b1;
        end else begin
            din_d       = din_q;
            shift_cnt_d = shift_cnt_q;
            sticky_d    = sticky_q;
        end

        if (switch < 8'(DEPTH)) begin
            rd_sel_d = switch[SW-1:0];
        end else begin
            rd_sel_d = SW'(DEPTH - 1);
        end
    end

    // State and output registers; the readback select keeps tracking the
    // switches even while reset is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_cnt_q <= {SW{1'b0}};
            din_q       <= {WIDTH{1'b0}};
            load_q      <= 1'b0;
            shift_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sticky_q    <= 1'b0;
            rd_q        <= {WIDTH{1'b0}};
            rd_sel_q    <= rd_sel_d;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            din_q       <= din_d;
            load_q      <= load_d;
            shift_q     <= shift_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sticky_q    <= sticky_d;
            rd_q        <= rd_d;
            rd_sel_q    <= rd_sel_d;
        end
    end

    // LED bus assembly from registered fields.
    always_comb begin
        led_s                                = 16'h0000;
        led_s[LED_BUSY_BIT]                  = busy_q;
        led_s[LED_STICKY_BIT]                = sticky_q;
        led_s[LED_CNT_LSB +: LED_CNT_W]      = LED_CNT_W'(shift_cnt_q);
        led_s[LED_RD_LSB +: LED_RD_W]        = LED_RD_W'(rd_q);
    end

    assign chain_load   = load_q;
    assign chain_din    = din_q;
    assign chain_shift  = shift_q;
    assign chain_rd_sel = rd_sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign led          = led_s;

endmodule

// File: tb/tb_reg_chain_seq.sv
// -----------------------------------------------------------------------------
// tb_reg_chain_seq
// Bench for reg_chain_seq (WIDTH=8, DEPTH=8, TICK_DIV=4) with a behavioural
// register chain attached. Expected load/shift/done events are queued when a
// run is started and popped as the DUT pulses.
// -----------------------------------------------------------------------------
module tb_reg_chain_seq;

    localparam int STEP0 = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  init_num = 8'h00;
    logic [7:0]  switch = 8'h04;
    logic        chain_load, chain_shift, busy, done;
    logic [7:0]  chain_din, chain_rd_data;
    logic [2:0]  chain_rd_sel;
    logic [15:0] led;

    int   vec_cnt = 0;
    int   miscmp  = 0;
    int   cyc     = 0;
    logic preload = 1'b0;
    logic [7:0] chain_m [8];

    typedef struct {
        int         t;
        int         kind;   // 0 load, 1 shift, 2 done
        logic [7:0] din;
    } ev_t;
    ev_t exp_q[$];

    reg_chain_seq dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .step          (step),
        .init_num      (init_num),
        .switch        (switch),
        .chain_load    (chain_load),
        .chain_din     (chain_din),
        .chain_shift   (chain_shift),
        .chain_rd_sel  (chain_rd_sel),
        .chain_rd_data (chain_rd_data),
        .busy          (busy),
        .done          (done),
        .led           (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural register chain.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) chain_m[i] <= 8'h30 + 8'(i);
        end else if (chain_load) begin
            chain_m[0] <= chain_din;
        end else if (chain_shift) begin
            for (int i = 7; i > 0; i--) chain_m[i] <= chain_m[i-1];
        end
    end

    assign chain_rd_data = chain_m[chain_rd_sel];

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b1; switch = 8'd4;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vec_cnt++;
            if ({chain_load, chain_shift, busy, done} !== 4'b0000) begin
                miscmp++;
                $display("FAIL reset_pulses: got %b expected 0000", {chain_load, chain_shift, busy, done});
            end
            vec_cnt++;
            if (led !== 16'h0000) begin
                miscmp++;
                $display("FAIL reset_led: got %h expected 0000", led);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
    endtask

    task automatic test_readback();
        logic [7:0] sw_tab  [5] = '{8'd9, 8'd2, 8'd8, 8'd7, 8'd0};
        logic [2:0] sel_tab [5] = '{3'd7, 3'd2, 3'd7, 3'd7, 3'd0};
        logic [7:0] prev;
        @(posedge clk); #1; preload = 1'b1; switch = 8'd4;
        @(posedge clk); #1; preload = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if (led[7:0] !== 8'h34 || chain_rd_sel !== 3'd4) begin
            miscmp++;
            $display("FAIL readback_base: got sel %0d led %h expected sel 4 led 34", chain_rd_sel, led[7:0]);
        end
        prev = 8'h34;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1; switch = sw_tab[i];
            @(posedge clk); @(negedge clk);
            vec_cnt++;
            if (chain_rd_sel !== sel_tab[i] || led[7:0] !== prev) begin
                miscmp++;
                $display("FAIL readback_sel sw=%0d: got sel %0d led %h expected sel %0d led %h",
                         sw_tab[i], chain_rd_sel, led[7:0], sel_tab[i], prev);
            end
            prev = 8'h30 + 8'(sel_tab[i]);
            @(posedge clk); @(negedge clk);
            vec_cnt++;
            if (led[7:0] !== prev) begin
                miscmp++;
                $display("FAIL readback_led sw=%0d: got %h expected %h", sw_tab[i], led[7:0], prev);
            end
        end
        @(posedge clk); #1; switch = 8'd4;
    endtask

    // One run with optional mid-run start, mid-run reset, start held high or
    // step-driven shifting; every cycle busy and the pulse stream are checked.
    task automatic run_scenario(input string name, input logic [7:0] seed, input int restart_off,
                                input int reset_off, input bit hold, input bit step_mode, input int max_k);
        int   n, t, last_t, end_c, c, kind_obs;
        bit   busy_exp;
        ev_t  e;
        @(posedge clk); #1;
        n = cyc; start = 1'b1; init_num = seed; step = 1'b0;
        exp_q.delete();
        e.t = n + 1; e.kind = 0; e.din = seed; exp_q.push_back(e);
        last_t = n + 1;
        for (int j = 1; j <= 7; j++) begin
            t = step_mode ? (n + STEP0 + 10 * (j - 1) + 1) : (n + 1 + j * 4);
            if (reset_off < 0 || t <= n + reset_off) begin
                e.t = t; e.kind = 1; e.din = 8'h00; exp_q.push_back(e);
            end
            last_t = t;
        end
        t = last_t + 1;
        if (reset_off < 0 || t <= n + reset_off) begin
            e.t = t; e.kind = 2; e.din = 8'h00; exp_q.push_back(e);
        end
        end_c = (reset_off < 0) ? (last_t + 1) : (n + reset_off);
        if (hold) begin
            e.t = end_c + 2; e.kind = 0; e.din = seed; exp_q.push_back(e);
        end
        for (int k = 1; k <= max_k; k++) begin
            @(posedge clk); #1;
            start    = hold || (k == restart_off);
            init_num = hold ? seed : ~seed;
            reset    = (reset_off > 0) && (k == reset_off || k == reset_off + 1);
            step     = step_mode && (k >= STEP0) && ((k - STEP0) % 10 == 0) && (k <= STEP0 + 60);
            @(negedge clk);
            c = cyc;
            busy_exp = (c >= n + 1 && c <= end_c) || (hold && c >= end_c + 2);
            vec_cnt++;
            if (busy !== busy_exp) begin
                miscmp++;
                $display("FAIL %s busy @+%0d: got %b expected %b", name, c - n, busy, busy_exp);
            end
            if (chain_load || chain_shift || done) begin
                kind_obs = chain_load ? 0 : (chain_shift ? 1 : 2);
                vec_cnt++;
                if (chain_load && chain_shift) begin
                    miscmp++;
                    $display("FAIL %s overlap @+%0d: got load and shift together", name, c - n);
                end else if (exp_q.size() == 0) begin
                    miscmp++;
                    $display("FAIL %s unexpected pulse kind %0d @+%0d: expected none", name, kind_obs, c - n);
                end else begin
                    e = exp_q.pop_front();
                    if (e.t !== c || e.kind !== kind_obs) begin
                        miscmp++;
                        $display("FAIL %s event: got kind %0d @+%0d expected kind %0d @+%0d",
                                 name, kind_obs, c - n, e.kind, e.t - n);
                    end else if (kind_obs == 0 && chain_din !== e.din) begin
                        miscmp++;
                        $display("FAIL %s chain_din: got %h expected %h", name, chain_din, e.din);
                    end
                end
            end
        end
        vec_cnt++;
        if (exp_q.size() != 0) begin
            miscmp++;
            $display("FAIL %s missing events: got %0d left expected 0", name, exp_q.size());
        end
        @(posedge clk); #1;
        start = 1'b0; step = 1'b0; reset = hold;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic check_led_hi(input string name, input logic [7:0] exp_hi, input logic [7:0] exp_lo, input bit chk_lo);
        @(negedge clk);
        vec_cnt++;
        if (led[15:8] !== exp_hi || (chk_lo && led[7:0] !== exp_lo)) begin
            miscmp++;
            $display("FAIL %s led: got %h expected %h%h", name, led, exp_hi, exp_lo);
        end
    endtask

    task automatic test_run();
        run_scenario("run", 8'd37, -1, -1, 1'b0, 1'b0, 35);
        check_led_hi("run", 8'h47, 8'h25, 1'b1);
    endtask

    task automatic test_midrun_start();
        run_scenario("restart", 8'hC3, 12, -1, 1'b0, 1'b0, 35);
        check_led_hi("restart", 8'h47, 8'hC3, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_scenario("held", 8'h5E, -1, -1, 1'b1, 1'b0, 33);
    endtask

    task automatic test_midrun_reset();
        run_scenario("midreset", 8'h9A, -1, 10, 1'b0, 1'b0, 40);
        check_led_hi("midreset", 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_step();
        run_scenario("step", 8'h6B, -1, -1, 1'b0, 1'b1, 75);
        check_led_hi("step", 8'h47, 8'h6B, 1'b1);
    endtask

    initial begin
        test_reset();
        test_readback();
`ifdef REG_CHAIN_STEP_EN
        test_step();
`else
        test_run();
        test_midrun_start();
        test_back_to_back();
        test_midrun_reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
